// File: rtl/button_pkg.sv
// button_pkg: shared constants and event-record helpers for the button event scheduler.
// BTN_AUTOREPEAT_EN adds a repeat flag above the id in each event record.
package button_pkg;
  localparam int CLK_HZ = 31_500_000;
  localparam int SAMPLE_HZ = 200;
  localparam int TICK_DIV_DEF = CLK_HZ / SAMPLE_HZ;
  localparam int REPEAT_DLY_DEF = 100;
  localparam int REPEAT_RATE_DEF = 20;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Event record is {repeat, id}; without auto-repeat only the id is stored.
  function automatic int evt_width(input int id_w);
`ifdef BTN_AUTOREPEAT_EN
    return id_w + 1;
`else
    return id_w;
`endif
  endfunction
endpackage

// File: rtl/button_event_fifo.sv
// button_event_fifo: synchronous FIFO for button events; push accepted when full only alongside a pop.
module button_event_fifo import button_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign dout = empty ? '0 : mem[rptr];
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
endmodule

// File: rtl/button_event_scheduler.sv
// button_event_scheduler: sample-tick prescaler plus round-robin serialiser of debounced button presses.
// Optional feature macro: BTN_AUTOREPEAT_EN (per-button hold counters generating repeat events).
module button_event_scheduler import button_pkg::*; #(
  parameter int NUM_BTN = 4,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_RATE = REPEAT_RATE_DEF
) (
  input  logic                            regular_clk,
  input  logic                            reset_n,
  output logic                            slow_tick,
  input  logic [NUM_BTN-1:0]              btn_pulse,
  input  logic [NUM_BTN-1:0]              btn_level,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [id_width(NUM_BTN)-1:0]    evt_id,
  output logic                            evt_repeat,
  output logic                            overflow,
  input  logic                            ovf_clear
);
  localparam int ID_W = id_width(NUM_BTN);
  localparam int EW = evt_width(ID_W);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] pre_cnt;
  logic [NUM_BTN-1:0] pend, rep, rep_fire, rep_set, gnt_mask, drop;
  logic [ID_W-1:0] rr, gnt_id, cand;
  logic gnt_vld, grant, pop, full, empty;
  logic [EW-1:0] din, dout;
  assign slow_tick = pre_cnt == CW'(TICK_DIV - 1);
  // Free-running prescaler producing the shared debouncer sample strobe.
  always_ff @(posedge regular_clk or negedge reset_n)
    if (!reset_n) pre_cnt <= '0;
    else pre_cnt <= slow_tick ? '0 : pre_cnt + CW'(1);
  // Round-robin search starting just after the last granted button; the lowest offset wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id = '0;
    cand = '0;
    for (int k = NUM_BTN; k >= 1; k--) begin
      cand = ID_W'((int'(rr) + k) % NUM_BTN);
      if (pend[cand]) begin
        gnt_vld = 1'b1;
        gnt_id = cand;
      end
    end
  end
  assign pop = evt_valid && evt_ready;
  assign grant = gnt_vld && (!full || pop);
  assign gnt_mask = grant ? (NUM_BTN'(1) << gnt_id) : '0;
  // A real press on top of a queued repeat replaces it instead of counting as lost.
  assign drop = btn_pulse & pend & ~rep & ~gnt_mask;
  assign rep_set = rep_fire & ~pend & ~btn_pulse;
  // Pending flags, arbitration pointer and sticky overflow (set beats clear).
  always_ff @(posedge regular_clk or negedge reset_n)
    if (!reset_n) begin
      pend <= '0;
      rr <= '0;
      overflow <= 1'b0;
    end else begin
      pend <= btn_pulse | rep_set | (pend & ~gnt_mask);
      rr <= grant ? gnt_id : rr;
      overflow <= (|drop) ? 1'b1 : ovf_clear ? 1'b0 : overflow;
    end
`ifdef BTN_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DLY + 1);
  logic [HW-1:0] hold [NUM_BTN];
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < NUM_BTN; i++)
      rep_fire[i] = btn_level[i] && slow_tick && hold[i] == HW'(REPEAT_DLY - 1);
  end
  // Hold counters reload to DLY-RATE after each fire so later repeats come every RATE ticks.
  always_ff @(posedge regular_clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_BTN; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++)
        hold[i] <= !btn_level[i] ? '0 : !slow_tick ? hold[i] :
                   rep_fire[i] ? HW'(REPEAT_DLY - REPEAT_RATE) : hold[i] + HW'(1);
    end
  // Repeat flag travels with the pending bit; a real press always clears it.
  always_ff @(posedge regular_clk or negedge reset_n)
    if (!reset_n) rep <= '0;
    else rep <= (rep | rep_set) & ~btn_pulse;
  assign din = {rep[gnt_id], gnt_id};
  assign evt_repeat = dout[EW-1];
`else
  logic unused_cfg;
  assign unused_cfg = ^{btn_level, REPEAT_DLY[0], REPEAT_RATE[0]};
  assign rep = '0;
  assign rep_fire = '0;
  assign din = gnt_id;
  assign evt_repeat = 1'b0;
`endif
  assign evt_id = dout[ID_W-1:0];
  assign evt_valid = !empty;
  button_event_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(regular_clk),
    .rst_n(reset_n),
    .push(grant),
    .din(din),
    .pop(pop),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_button_event_scheduler.sv
// tb_button_event_scheduler: directed checks of tick, latency, round-robin order, overflow and full-FIFO bypass.
module tb_button_event_scheduler;
  logic regular_clk = 1'b0;
  logic reset_n = 1'b0;
  logic slow_tick;
  logic [3:0] btn_pulse = '0;
  logic [3:0] btn_level = '0;
  logic evt_valid;
  logic evt_ready = 1'b0;
  logic [1:0] evt_id;
  logic evt_repeat;
  logic overflow;
  logic ovf_clear = 1'b0;
  int checks = 0;
  int errors = 0;
  int exp_rr[4] = '{1, 2, 3, 0};
  int exp_bp[6] = '{0, 1, 2, 3, 0, 1};
  always #5 regular_clk = ~regular_clk;
  button_event_scheduler #(
    .NUM_BTN(4), .TICK_DIV(8), .FIFO_DEPTH(4), .REPEAT_DLY(3), .REPEAT_RATE(2)
  ) dut (
    .regular_clk(regular_clk),
    .reset_n(reset_n),
    .slow_tick(slow_tick),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .evt_repeat(evt_repeat),
    .overflow(overflow),
    .ovf_clear(ovf_clear)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge regular_clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    btn_pulse = '0;
    btn_level = '0;
    evt_ready = 1'b0;
    ovf_clear = 1'b0;
    #1;
    chk("rst_tick", slow_tick, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_repeat", evt_repeat, 0);
    chk("rst_ovf", overflow, 0);
    step();
    step();
    reset_n = 1'b1;
  endtask
  initial begin
    // Prescaler: cycle 0 is the first cycle after release.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("tick_c%0d", k), slow_tick, (k == 7 || k == 15));
      step();
    end
    chk("idle_valid", evt_valid, 0);
    // Single press latency: visible at N+2 for one cycle.
    evt_ready = 1'b1;
    btn_pulse = 4'b0100;
    step();
    btn_pulse = '0;
    chk("lat_n1_valid", evt_valid, 0);
    step();
    chk("lat_n2_valid", evt_valid, 1);
    chk("lat_n2_id", evt_id, 2);
    chk("lat_n2_rep", evt_repeat, 0);
    step();
    chk("lat_n3_valid", evt_valid, 0);
    // All four at once from rr=0: order 1,2,3,0.
    do_reset();
    evt_ready = 1'b1;
    btn_pulse = 4'b1111;
    step();
    btn_pulse = '0;
    chk("rr_n1_valid", evt_valid, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_valid%0d", i), evt_valid, 1);
      chk($sformatf("rr_id%0d", i), evt_id, exp_rr[i]);
      step();
    end
    chk("rr_drained", evt_valid, 0);
    chk("rr_ovf", overflow, 0);
    // Fill the FIFO with 0..3 while stalled.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      btn_pulse = 4'(1 << i);
      step();
    end
    btn_pulse = 4'b0011;
    step();
    chk("full_valid", evt_valid, 1);
    chk("full_id", evt_id, 0);
    chk("full_ovf0", overflow, 0);
    btn_pulse = 4'b0001;
    step();
    btn_pulse = '0;
    chk("drop_ovf", overflow, 1);
    step();
    chk("drop_ovf_sticky", overflow, 1);
    chk("stall_id", evt_id, 0);
    ovf_clear = 1'b1;
    btn_pulse = 4'b0001;
    step();
    btn_pulse = '0;
    chk("clr_vs_drop", overflow, 1);
    step();
    ovf_clear = 1'b0;
    chk("clr_ovf", overflow, 0);
    // Pop and push together on a full FIFO; pending 0 and 1 follow the original entries.
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_valid%0d", i), evt_valid, 1);
      chk($sformatf("bp_id%0d", i), evt_id, exp_bp[i]);
      step();
    end
    chk("bp_drained", evt_valid, 0);
    chk("bp_ovf", overflow, 0);
`ifdef BTN_AUTOREPEAT_EN
    begin
      int npress = 0;
      int nrep = 0;
      do_reset();
      evt_ready = 1'b1;
      btn_level = 4'b1000;
      btn_pulse = 4'b1000;
      for (int c = 0; c < 64; c++) begin
        if (evt_valid) begin
          if (evt_repeat) nrep++;
          else npress++;
        end
        step();
        btn_pulse = '0;
      end
      btn_level = '0;
      for (int c = 0; c < 40; c++) begin
        if (evt_valid) begin
          if (evt_repeat) nrep++;
          else npress++;
        end
        step();
      end
      chk("ar_press", npress, 1);
      chk("ar_repeats", nrep, 3);
      chk("ar_ovf", overflow, 0);
    end
`else
    chk("no_ar_repeat", evt_repeat, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
